// File: rtl/sdram_stream_reader.sv
// rtl/sdram_stream_reader.sv - sequential single-word sdram_bus reader feeding a valid/ready stream
module sdram_stream_reader #(
    parameter int ADDR_BITS  = 24,
    parameter int DATA_BITS  = 16,
    parameter int LEN_BITS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [LEN_BITS-1:0]  length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [DATA_BITS-1:0] mem_data_write,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_data_read
);

    localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS  = PTR_BITS + 1;
    localparam int ROOM_BITS = PTR_BITS + 2;
    localparam logic [ROOM_BITS-1:0] DEPTH_R = ROOM_BITS'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   mem_req_q, mem_req_d;
    logic [ADDR_BITS-1:0]   mem_address_q, mem_address_d;
    logic [LEN_BITS-1:0]    remaining_q, remaining_d;
    logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]    fifo_count_q, fifo_count_d;
    logic [DATA_BITS-1:0]   fifo_mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   flush;
    logic                   room_one;
    logic                   room_two;
    logic [ROOM_BITS-1:0]   count_ext;

    assign count_ext = ROOM_BITS'(fifo_count_q);
    // room_two is used when issuing in the same cycle as an ack whose word is
    // not yet reflected in the registered count; pops never add room early.
    assign room_one  = (count_ext + ROOM_BITS'(1)) <= DEPTH_R;
    assign room_two  = (count_ext + ROOM_BITS'(2)) <= DEPTH_R;
    assign pop       = (fifo_count_q != '0) && out_ready;

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        mem_req_d     = 1'b0;
        mem_address_d = mem_address_q;
        remaining_d   = remaining_q;
        push          = 1'b0;
        flush         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d        = 1'b1;
                        remaining_d   = length;
                        mem_address_d = start_addr;
                        if (room_one) begin
                            mem_req_d = 1'b1;
                            state_d   = S_WAIT;
                        end else begin
                            state_d   = S_ISSUE;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (abort) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (room_one) begin
                    mem_req_d = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    flush = 1'b1;
                    if (mem_ack) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ABORT;
                    end
                end else if (mem_ack) begin
                    push          = 1'b1;
                    mem_address_d = mem_address_q + ADDR_BITS'(1);
                    remaining_d   = remaining_q - LEN_BITS'(1);
                    if (remaining_q == LEN_BITS'(1)) begin
                        state_d = S_DRAIN;
                    end else if (room_two) begin
                        mem_req_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    flush   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (fifo_count_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ABORT: begin
                // The outstanding word is swallowed; the FIFO was already flushed.
                if (mem_ack) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_BITS'(push);
        rd_ptr_d     = rd_ptr_q + PTR_BITS'(pop);
        fifo_count_d = fifo_count_q;
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_BITS'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_BITS'(1);
            default: fifo_count_d = fifo_count_q;
        endcase
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fifo_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_address_q <= '0;
            remaining_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_req_q     <= mem_req_d;
            mem_address_q <= mem_address_d;
            remaining_q   <= remaining_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_count_q  <= fifo_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            fifo_mem_q[wr_ptr_q] <= mem_data_read;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign mem_req        = mem_req_q;
    assign mem_address    = mem_address_q;
    assign mem_we         = 1'b0;
    assign mem_data_write = '0;
    assign out_valid      = (fifo_count_q != '0);
    assign out_data       = fifo_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_sdram_stream_reader.sv
// tb/tb_sdram_stream_reader.sv - scoreboard bench for sdram_stream_reader with a memory responder model
module tb_sdram_stream_reader;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int LW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] length = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_write;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_data_read = '0;

    sdram_stream_reader #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .LEN_BITS  (LW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .start_addr    (start_addr),
        .length        (length),
        .abort         (abort),
        .busy          (busy),
        .done          (done),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_address   (mem_address),
        .mem_data_write(mem_data_write),
        .mem_ack       (mem_ack),
        .mem_data_read (mem_data_read)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [DW-1:0] preload [logic [AW-1:0]];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];

    int            req_count = 0;
    int            done_count = 0;
    int            ack_count = 0;
    bit            pending = 1'b0;
    int            ack_cd = 0;
    int            ack_delay_fix = 2;
    int            ready_mode = 1;
    logic [AW-1:0] pend_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        if (preload.exists(a)) return preload[a];
        return {a[7:0] ^ a[23:16], a[15:8]} ^ 16'h5A3C;
    endfunction

    // Memory channel model: one ack per request after a programmable delay.
    initial begin
        bit ack_now;
        forever begin
            @(negedge clk);
            ack_now = 1'b0;
            if (ack_cd == 1) begin
                mem_ack       = 1'b1;
                mem_data_read = mem_word(pend_addr);
                ack_now       = 1'b1;
                ack_count++;
            end else begin
                mem_ack       = 1'b0;
                mem_data_read = DW'($urandom);
            end
            if (ack_cd > 0) ack_cd--;
            #3;
            if (mem_req === 1'b1) begin
                req_count++;
                chk("single_outstanding", 64'(pending), 64'd0);
                chk("mem_we_zero", 64'(mem_we), 64'd0);
                chk("mem_data_write_zero", 64'(mem_data_write), 64'd0);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h required no request", mem_address);
                end else begin
                    chk("req_addr", 64'(mem_address), 64'(exp_addr.pop_front()));
                end
            end
            if (ack_now) pending = 1'b0;
            if (mem_req === 1'b1) begin
                pending   = 1'b1;
                pend_addr = mem_address;
                ack_cd    = (ack_delay_fix != 0) ? ack_delay_fix : int'($urandom_range(1, 4));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_data.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h required no word", out_data);
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_data.pop_front()));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (done === 1'b1) begin
                done_count++;
                chk("busy_low_at_done", 64'(busy), 64'd0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input logic [AW-1:0] a, input int l);
        for (int i = 0; i < l; i++) begin
            logic [AW-1:0] ea;
            ea = AW'((64'(a) + 64'(i)) % (64'd1 << AW));
            exp_addr.push_back(ea);
            exp_data.push_back(mem_word(ea));
        end
        @(negedge clk);
        start      = 1'b1;
        start_addr = a;
        length     = LW'(l);
        @(negedge clk);
        start      = 1'b0;
        start_addr = AW'($urandom);
        length     = LW'($urandom);
        #4;
        if (l != 0) begin
            chk("busy_after_start", 64'(busy), 64'd1);
            chk("req_latency", 64'(mem_req), 64'd1);
        end else begin
            chk("zero_len_done", 64'(done), 64'd1);
            chk("zero_len_busy", 64'(busy), 64'd0);
            chk("zero_len_no_req", 64'(mem_req), 64'd0);
        end
    endtask

    task automatic wait_done(input int d0, input int limit);
        int t = 0;
        while (done_count == d0 && t < limit) begin
            @(negedge clk);
            #4;
            t++;
        end
        if (done_count == d0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done in %0d cycles required one done pulse", limit);
        end
        tick(3);
        #4;
        chk("done_once", 64'(done_count), 64'(d0 + 1));
        chk("all_reqs_seen", 64'(exp_addr.size()), 64'd0);
        chk("all_words_seen", 64'(exp_data.size()), 64'd0);
        chk("idle_out_valid", 64'(out_valid), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int d0;
        int r0;
        int a0;
        int t;
        preload[24'h000010] = 16'h1111;
        preload[24'h000011] = 16'h2222;
        preload[24'h000012] = 16'h3333;
        preload[24'h000013] = 16'h4444;

        tick(3);
        reset_n = 1'b1;
        #4;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // Basic read of the preloaded words
        ready_mode = 1; ack_delay_fix = 2;
        d0 = done_count; r0 = req_count;
        launch(24'h000010, 4);
        wait_done(d0, 100);
        chk("basic_req_count", 64'(req_count - r0), 64'd4);

        // Backpressure: a full FIFO stops issuing
        ready_mode = 0; ack_delay_fix = 0;
        d0 = done_count; r0 = req_count;
        launch(24'h000200, 8);
        tick(40);
        #4;
        chk("bp_req_count_stalled", 64'(req_count - r0), 64'd4);
        chk("bp_mem_req_low", 64'(mem_req), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        ready_mode = 1;
        wait_done(d0, 200);
        chk("bp_req_count_total", 64'(req_count - r0), 64'd8);

        // Address wrap-around
        d0 = done_count; r0 = req_count;
        launch(24'hFFFFFF, 2);
        wait_done(d0, 100);
        chk("wrap_req_count", 64'(req_count - r0), 64'd2);

        // Zero length
        d0 = done_count; r0 = req_count;
        launch(24'h000055, 0);
        tick(3);
        #4;
        chk("zero_len_done_count", 64'(done_count), 64'(d0 + 1));
        chk("zero_len_req_count", 64'(req_count - r0), 64'd0);

        // Start while busy is ignored
        ready_mode = 2;
        d0 = done_count; r0 = req_count;
        launch(24'h000400, 6);
        tick(3);
        start = 1'b1; start_addr = 24'h000999; length = 16'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(d0, 300);
        chk("busy_start_req_count", 64'(req_count - r0), 64'd6);

        // Abort with an outstanding request, ack five cycles later
        ready_mode = 1; ack_delay_fix = 5;
        d0 = done_count; r0 = req_count; a0 = ack_count;
        launch(24'h000800, 4);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        #4;
        chk("abort_no_done_before_ack", 64'(done_count), 64'(d0));
        wait_done(d0, 50);
        chk("abort_done_after_ack", 64'(ack_count - a0), 64'd1);
        chk("abort_req_count", 64'(req_count - r0), 64'd1);

        // Reset in the middle of a transfer
        d0 = done_count; r0 = req_count; a0 = ack_count;
        launch(24'h000900, 4);
        @(negedge clk);
        reset_n = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(negedge clk);
        reset_n = 1'b1;
        #4;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_mem_address", 64'(mem_address), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        t = 0;
        while (pending && t < 20) begin
            @(negedge clk);
            #4;
            t++;
        end
        tick(3);
        #4;
        chk("midrst_late_ack_seen", 64'(ack_count - a0), 64'd1);
        chk("midrst_late_ack_ignored", 64'(out_valid), 64'd0);
        ack_delay_fix = 0;
        d0 = done_count; r0 = req_count;
        launch(24'h001234, 1);
        wait_done(d0, 50);
        chk("post_rst_req_count", 64'(req_count - r0), 64'd1);

        // Randomized transfers
        ready_mode = 2;
        for (int k = 0; k < 25; k++) begin
            logic [AW-1:0] ra;
            int            rl;
            ra = AW'($urandom);
            if (k % 5 == 0) ra = 24'hFFFFFF - AW'($urandom_range(0, 3));
            rl = int'($urandom_range(1, 10));
            d0 = done_count;
            launch(ra, rl);
            wait_done(d0, 400);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish within 50000 cycles required completion");
        $fatal(1);
    end

endmodule

// File: doc/sdram_stream_reader.md
Name: sdram_stream_reader

Overview:
- Initiator-side client for one sdram_bus channel of the sdram controller; it drives req/we/address and consumes ack/data_read.
- Given a start address and word count, it issues sequential single-word reads and buffers the returned words in a small FIFO.
- Words are presented to a consumer as a valid/ready stream.
- Typical users: pattern/sprite fetchers and the loader verification path that reads back what a writer channel stored.

Parameters:
- ADDR_BITS, 24: sdram_bus word-address width. Matches the controller channel.
- DATA_BITS, 16: word width.
- LEN_BITS, 16: width of the transfer-length field.
- FIFO_DEPTH, 4: output buffer depth in words. Must be a power of two, at least 2.

Ports:
- clk  in  1: system clock, same clock as the sdram controller.
- reset_n  in  1: synchronous, active-low reset.
- start  in  1: one-cycle pulse that launches a transfer. Ignored while busy=1.
- start_addr  in  ADDR_BITS: first word address, sampled when start is accepted.
- length  in  LEN_BITS: number of words, sampled when start is accepted.
- abort  in  1: cancels the current transfer. Has priority over start.
- busy  out  1: high from the cycle after start is accepted until done.
- done  out  1: one-cycle pulse when the transfer completes or the abort completes.
- out_data  out  DATA_BITS: FIFO head word.
- out_valid  out  1: FIFO not empty.
- out_ready  in  1: consumer accepts out_data when out_valid && out_ready.
- mem_req  out  1: one-cycle request pulse to the channel.
- mem_we  out  1: always 0.
- mem_address  out  ADDR_BITS: request address, held stable until ack.
- mem_data_write  out  DATA_BITS: always 0.
- mem_ack  in  1: one-cycle pulse from the controller when the request completes. mem_data_read is valid in that cycle.
- mem_data_read  in  DATA_BITS: read data.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - busy=0, done=0, mem_req=0, mem_address=0, out_valid=0.
  - FIFO emptied; state IDLE.
  - Any ack arriving after reset is ignored.
- States and transitions:
  - IDLE: on start with length≠0, latch addr/remaining and go to ISSUE.
  - IDLE: on start with length=0, pulse done the next cycle, busy stays 0, no request is issued.
  - ISSUE: when fifo_count + 1 ≤ FIFO_DEPTH, assert mem_req for exactly one cycle with mem_address=addr, then go to WAIT.
  - ISSUE: otherwise hold with mem_req=0.
  - WAIT: on mem_ack, push mem_data_read into the FIFO, addr←addr+1, remaining←remaining−1.
  - WAIT: if remaining becomes 0, go to DRAIN; otherwise go to ISSUE.
  - DRAIN: when the FIFO is empty, pulse done, drop busy and go to IDLE.
- Latency and ordering:
  - start accepted at cycle N → mem_req high at N+1.
  - mem_ack at cycle M → out_valid high at M+1, earliest next mem_req at M+1.
  - At most one outstanding request at any time.
  - mem_req is never asserted while in WAIT.
- Flow control:
  - The room check counts the outstanding word, so the FIFO never overflows.
  - A full FIFO with out_ready=0 stalls issuing indefinitely.
  - Data is delivered in address order with no gaps.
- Address arithmetic: addr increments modulo 2^ADDR_BITS. '1 wraps to 0 with no error.
- Simultaneous events:
  - FIFO push and pop in the same cycle leave the count unchanged.
  - A pop in the same cycle as the room check frees space only from the next cycle on (registered count).
- Abort:
  - Stops further requests immediately.
  - If in WAIT, the outstanding ack is awaited and its data discarded.
  - The FIFO is then flushed, done pulses and the state returns to IDLE.
  - abort in IDLE has no effect.
  - abort and start in the same cycle: abort wins, start is ignored.
- Outputs mem_we and mem_data_write are constant 0. This is a read-only initiator.

Test Plan:
- Basic read:
  - Stimulus: a writer channel has preloaded 0x000010..0x000013 = 0x1111, 0x2222, 0x3333, 0x4444; start addr=0x000010, len=4, out_ready=1.
  - Required: 4 mem_req pulses at addresses 0x10..0x13; the stream delivers the 4 words in order; done pulses once; busy falls with done.
- Backpressure:
  - Stimulus: len=8 with FIFO_DEPTH=4, out_ready=0.
  - Required: exactly 4 requests, then mem_req stays 0.
  - Then raise out_ready: the remaining 4 requests follow, all 8 words arrive in order, none lost or duplicated.
- Wrap-around:
  - Stimulus: start_addr='1 (0xFFFFFF), len=2.
  - Required: requests to 0xFFFFFF then 0x000000; data matches the memory contents.
- Zero length / start while busy:
  - Stimulus: start with len=0.
  - Required: done one cycle later, no mem_req.
  - Stimulus: a second start during an active transfer.
  - Required: it is ignored; the first transfer completes unchanged.
- Abort with outstanding request:
  - Stimulus: abort asserted in WAIT, ack arriving 5 cycles later.
  - Required: no further mem_req; the acked data is not output; out_valid=0; done pulses after the ack; busy=0.
- Reset mid-transfer:
  - Stimulus: reset_n=0 for one clk while in WAIT.
  - Required: all outputs at reset values next cycle; a late mem_ack produces no FIFO write; a new start with len=1 works normally.
